// File: rtl/mem_ctrl.sv
// Data-memory and instruction-fetch controller: serialises byte/half/word loads and
// stores onto a byte-wide RAM and fetches words from a program ROM, each with its own FSM.
module mem_ctrl #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] DATA_START = 32'hC000_0000,
  parameter logic [XLEN-1:0] CODE_START = 32'h8000_0000,
  parameter int              RAM_AW     = 16,
  parameter int              ROM_AW     = 14,
  parameter int              RAM_LAT    = 1,
  parameter int              ROM_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_main_req_valid,
  output logic              o_main_req_ready,
  input  logic              i_main_we,
  input  logic [1:0]        i_main_size,
  input  logic              i_main_unsigned,
  input  logic [XLEN-1:0]   i_main_addr,
  input  logic [XLEN-1:0]   i_main_wdata,
  output logic              o_main_resp_valid,
  output logic [XLEN-1:0]   o_main_rdata,
  output logic              o_main_err,
  input  logic              i_fetch_req_valid,
  output logic              o_fetch_req_ready,
  input  logic [XLEN-1:0]   i_fetch_addr,
  output logic              o_fetch_resp_valid,
  output logic              o_fetch_err,
  output logic [31:0]       o_fetch_instr,
  output logic [RAM_AW-1:0] o_ram_addr,
  output logic [7:0]        o_ram_wdata,
  output logic              o_ram_we,
  output logic              o_ram_re,
  input  logic [7:0]        i_ram_rdata,
  output logic [ROM_AW-1:0] o_rom_addr,
  output logic              o_rom_re,
  input  logic [31:0]       i_rom_q
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] F_IDLE = 2'd0;
  localparam logic [1:0] F_RD   = 2'd1;
  localparam logic [1:0] F_DONE = 2'd2;

  localparam logic [XLEN:0]   RAM_LIMIT = (XLEN+1)'(1) << RAM_AW;
  localparam logic [XLEN-1:0] ROM_LIMIT = XLEN'(1) << ROM_AW;

  // r_run holds both ready signals low until the first clock after reset release
  logic              r_run;
  logic [1:0]        r_state;
  logic [2:0]        r_cnt;
  logic [1:0]        r_cap;
  logic [2:0]        r_n;
  logic              r_uns;
  logic [RAM_AW-1:0] r_off;
  logic [31:0]       r_wdata;
  logic [31:0]       r_res;
  logic [RAM_LAT-1:0] r_tag;
  logic              r_resp_valid;
  logic [XLEN-1:0]   r_rdata;
  logic              r_err;

  logic [1:0]        r_fstate;
  logic [1:0]        r_fcnt;
  logic [ROM_AW-1:0] r_rom_addr;
  logic              r_fresp_valid;
  logic              r_ferr;
  logic [31:0]       r_finstr;

  logic              w_main_fire;
  logic [2:0]        w_n;
  logic [XLEN-1:0]   w_off;
  logic [XLEN:0]     w_end;
  logic              w_err;
  logic              w_ram_we;
  logic              w_ram_re;
  logic              w_tag_out;
  logic              w_last_cap;
  logic [7:0]        w_wbyte;
  logic [31:0]       w_res_next;
  logic [7:0]        w_sh;
  logic [XLEN-1:0]   w_shl;
  logic [XLEN-1:0]   w_srl;
  logic signed [XLEN-1:0] w_sra;
  logic [XLEN-1:0]   w_ext;

  logic              w_fetch_fire;
  logic [XLEN-1:0]   w_foff;
  logic [XLEN-1:0]   w_fidx;
  logic              w_ferr;

  always_comb begin
    case (i_main_size)
      2'd0:    w_n = 3'd1;
      2'd1:    w_n = 3'd2;
      2'd2:    w_n = 3'd4;
      default: w_n = 3'd0;
    endcase
  end

  // The end-of-access sum is one bit wider so a wrap past 2^XLEN still reads as out of range
  assign w_off       = i_main_addr - DATA_START;
  assign w_end       = {1'b0, w_off} + {{(XLEN-2){1'b0}}, w_n};
  assign w_err       = (i_main_size == 2'd3)
                     | ((i_main_size == 2'd1) & i_main_addr[0])
                     | ((i_main_size == 2'd2) & (i_main_addr[1:0] != 2'd0))
                     | (i_main_addr < DATA_START)
                     | (w_end > RAM_LIMIT);
  assign w_main_fire = r_run & (r_state == S_IDLE) & i_main_req_valid;

  assign w_ram_we   = (r_state == S_WR);
  assign w_ram_re   = (r_state == S_RD) && (r_cnt < r_n);
  assign w_tag_out  = r_tag[RAM_LAT-1];
  assign w_last_cap = w_tag_out && ({1'b0, r_cap} == (r_n - 3'd1));
  assign w_wbyte    = r_wdata[{r_cnt[1:0], 3'b000} +: 8];

  always_comb begin
    w_res_next = r_res;
    if (w_tag_out) begin
      for (int k = 0; k < 4; k++) begin
        if (r_cap == 2'(k)) w_res_next[8*k +: 8] = i_ram_rdata;
      end
    end
  end

  // Extension: park the loaded field at the top, then shift back logically or arithmetically
  assign w_sh  = 8'(XLEN) - {2'b00, r_n, 3'b000};
  assign w_shl = XLEN'(w_res_next) << w_sh;
  assign w_srl = w_shl >> w_sh;
  assign w_sra = $signed(w_shl) >>> w_sh;
  assign w_ext = r_uns ? w_srl : w_sra;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run        <= 1'b0;
      r_state      <= S_IDLE;
      r_cnt        <= 3'd0;
      r_cap        <= 2'd0;
      r_n          <= 3'd0;
      r_uns        <= 1'b0;
      r_off        <= '0;
      r_wdata      <= 32'd0;
      r_res        <= 32'd0;
      r_tag        <= '0;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
    end else begin
      r_run <= 1'b1;
      r_tag <= RAM_LAT'({r_tag, w_ram_re});
      case (r_state)
        S_IDLE: begin
          if (w_main_fire) begin
            r_off   <= w_off[RAM_AW-1:0];
            r_n     <= w_n;
            r_uns   <= i_main_unsigned;
            r_wdata <= i_main_wdata[31:0];
            r_cnt   <= 3'd0;
            r_cap   <= 2'd0;
            r_res   <= 32'd0;
            if (w_err) begin
              r_state      <= S_DONE;
              r_resp_valid <= 1'b1;
              r_err        <= 1'b1;
              r_rdata      <= '0;
            end else if (i_main_we) begin
              r_state <= S_WR;
            end else begin
              r_state <= S_RD;
            end
          end
        end
        S_WR: begin
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == (r_n - 3'd1)) begin
            r_state      <= S_DONE;
            r_resp_valid <= 1'b1;
            r_err        <= 1'b0;
            r_rdata      <= '0;
          end
        end
        S_RD: begin
          if (w_ram_re) r_cnt <= r_cnt + 3'd1;
          if (w_tag_out) begin
            r_res <= w_res_next;
            r_cap <= r_cap + 2'd1;
          end
          if (w_last_cap) begin
            r_state      <= S_DONE;
            r_resp_valid <= 1'b1;
            r_err        <= 1'b0;
            r_rdata      <= w_ext;
          end
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign o_main_req_ready  = r_run & (r_state == S_IDLE);
  assign o_main_resp_valid = r_resp_valid;
  assign o_main_rdata      = r_rdata;
  assign o_main_err        = r_err;
  assign o_ram_we          = w_ram_we;
  assign o_ram_re          = w_ram_re;
  assign o_ram_addr        = (w_ram_we | w_ram_re) ? (r_off + RAM_AW'(r_cnt)) : '0;
  assign o_ram_wdata       = w_ram_we ? w_wbyte : 8'd0;

  assign w_foff       = i_fetch_addr - CODE_START;
  assign w_fidx       = w_foff >> 2;
  assign w_ferr       = (i_fetch_addr[1:0] != 2'd0)
                      | (i_fetch_addr < CODE_START)
                      | (w_fidx >= ROM_LIMIT);
  assign w_fetch_fire = r_run & (r_fstate == F_IDLE) & i_fetch_req_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fstate      <= F_IDLE;
      r_fcnt        <= 2'd0;
      r_rom_addr    <= '0;
      r_fresp_valid <= 1'b0;
      r_ferr        <= 1'b0;
      r_finstr      <= 32'd0;
    end else begin
      case (r_fstate)
        F_IDLE: begin
          if (w_fetch_fire) begin
            r_rom_addr <= w_fidx[ROM_AW-1:0];
            r_fcnt     <= 2'd0;
            if (w_ferr) begin
              r_fstate      <= F_DONE;
              r_fresp_valid <= 1'b1;
              r_ferr        <= 1'b1;
              r_finstr      <= 32'd0;
            end else begin
              r_fstate <= F_RD;
            end
          end
        end
        F_RD: begin
          r_fcnt <= r_fcnt + 2'd1;
          if (r_fcnt == 2'(ROM_LAT)) begin
            r_fstate      <= F_DONE;
            r_fresp_valid <= 1'b1;
            r_ferr        <= 1'b0;
            r_finstr      <= i_rom_q;
          end
        end
        default: begin
          r_fresp_valid <= 1'b0;
          r_fstate      <= F_IDLE;
        end
      endcase
    end
  end

  assign o_fetch_req_ready  = r_run & (r_fstate == F_IDLE);
  assign o_fetch_resp_valid = r_fresp_valid;
  assign o_fetch_err        = r_ferr;
  assign o_fetch_instr      = r_finstr;
  assign o_rom_re           = (r_fstate == F_RD) && (r_fcnt == 2'd0);
  assign o_rom_addr         = o_rom_re ? r_rom_addr : '0;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM and word ROM models, a reference memory image and
// per-transaction expectations derived from addresses, sizes and latencies.
module tb_mem_ctrl;
  localparam int          RAM_LAT_P  = 2;
  localparam int          ROM_LAT_P  = 1;
  localparam logic [31:0] DATA_START = 32'hC000_0000;
  localparam logic [31:0] CODE_START = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        main_valid, main_we, main_uns;
  logic [1:0]  main_size;
  logic [31:0] main_addr, main_wdata;
  logic        main_ready, main_resp, main_err;
  logic [31:0] main_rdata;
  logic        fetch_valid, fetch_ready, fetch_resp, fetch_err;
  logic [31:0] fetch_addr, fetch_instr;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata, ram_rdata, rd1;
  logic        ram_we, ram_re;
  logic [13:0] rom_addr;
  logic        rom_re;
  logic [31:0] rom_q;

  logic [7:0]  ram_mem [0:65535];
  logic [7:0]  ref_ram [0:65535];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  mem_ctrl #(
    .XLEN(32), .DATA_START(DATA_START), .CODE_START(CODE_START),
    .RAM_AW(16), .ROM_AW(14), .RAM_LAT(RAM_LAT_P), .ROM_LAT(ROM_LAT_P)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_main_req_valid(main_valid), .o_main_req_ready(main_ready),
    .i_main_we(main_we), .i_main_size(main_size), .i_main_unsigned(main_uns),
    .i_main_addr(main_addr), .i_main_wdata(main_wdata),
    .o_main_resp_valid(main_resp), .o_main_rdata(main_rdata), .o_main_err(main_err),
    .i_fetch_req_valid(fetch_valid), .o_fetch_req_ready(fetch_ready),
    .i_fetch_addr(fetch_addr), .o_fetch_resp_valid(fetch_resp),
    .o_fetch_err(fetch_err), .o_fetch_instr(fetch_instr),
    .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata), .o_ram_we(ram_we),
    .o_ram_re(ram_re), .i_ram_rdata(ram_rdata),
    .o_rom_addr(rom_addr), .o_rom_re(rom_re), .i_rom_q(rom_q)
  );

  function automatic logic [31:0] rom_fn(input logic [13:0] a);
    return {2'b00, a, a[7:0], a[7:0]} ^ 32'h5A5A_0F0F;
  endfunction

  // Two-stage RAM read pipe, single-stage ROM read
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    if (ram_re) rd1 <= ram_mem[ram_addr];
    ram_rdata <= rd1;
    if (rom_re) rom_q <= rom_fn(rom_addr);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_load(input logic [31:0] off, input int n, input logic uns);
    longint v = 0;
    for (int i = 0; i < n; i++) v = v + (longint'(ref_ram[16'(off + i)]) << (8 * i));
    if (!uns && ((v >> (8 * n - 1)) & 1) == 1) v = v - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  task automatic main_txn(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
    int n, exp_lat, lat;
    logic [31:0] off, exp_rd, got_rd;
    logic err, got_err, exp_we, exp_re;
    bit hs;
    n = (size == 0) ? 1 : (size == 1) ? 2 : (size == 2) ? 4 : 0;
    off = addr - DATA_START;
    err = (size == 3) || (size == 1 && addr[0]) || (size == 2 && addr[1:0] != 0)
       || (addr < DATA_START) || (longint'(off) + n > 65536);
    exp_lat = err ? 1 : we ? n + 1 : n + RAM_LAT_P + 1;
    exp_rd = (err || we) ? 32'd0 : exp_load(off, n, uns);
    @(negedge clk);
    main_valid = 1'b1; main_we = we; main_size = size; main_uns = uns;
    main_addr = addr; main_wdata = wdata;
    hs = 0;
    for (int w = 0; w < 20; w++) begin
      if (main_ready) begin hs = 1; break; end
      @(negedge clk);
    end
    chk("m_ready", 64'(hs), 64'd1);
    @(posedge clk); #1 main_valid = 1'b0;
    lat = 0; got_rd = 0; got_err = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      exp_we = !err && we && k <= n;
      exp_re = !err && !we && k <= n;
      chk("m_we", 64'(ram_we), 64'(exp_we));
      chk("m_re", 64'(ram_re), 64'(exp_re));
      if (exp_we || exp_re) chk("m_addr", 64'(ram_addr), 64'(16'(off + k - 1)));
      if (exp_we) chk("m_wdata", 64'(ram_wdata), 64'(wdata[8*(k-1) +: 8]));
      if (main_resp) begin lat = k; got_rd = main_rdata; got_err = main_err; end
    end
    chk("m_lat", 64'(lat), 64'(exp_lat));
    chk("m_err", 64'(got_err), 64'(err));
    chk("m_rdata", 64'(got_rd), 64'(exp_rd));
    if (!err && we) for (int i = 0; i < n; i++) ref_ram[16'(off + i)] = wdata[8*i +: 8];
    $display("main we=%0d size=%0d uns=%0d addr=%h wdata=%h rdata=%h err=%0d lat=%0d",
             we, size, uns, addr, wdata, got_rd, got_err, lat);
  endtask

  task automatic fetch_txn(input logic [31:0] addr);
    int exp_lat, lat;
    logic [31:0] foff, idx, exp_i, got_i;
    logic err, got_e, exp_re;
    bit hs;
    foff = addr - CODE_START;
    idx = foff / 4;
    err = (addr % 4 != 0) || (addr < CODE_START) || (idx >= 16384);
    exp_lat = err ? 1 : ROM_LAT_P + 2;
    exp_i = err ? 32'd0 : rom_fn(idx[13:0]);
    @(negedge clk);
    fetch_valid = 1'b1; fetch_addr = addr;
    hs = 0;
    for (int w = 0; w < 20; w++) begin
      if (fetch_ready) begin hs = 1; break; end
      @(negedge clk);
    end
    chk("f_ready", 64'(hs), 64'd1);
    @(posedge clk); #1 fetch_valid = 1'b0;
    lat = 0; got_i = 0; got_e = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      exp_re = !err && k == 1;
      chk("f_re", 64'(rom_re), 64'(exp_re));
      if (exp_re) chk("f_addr", 64'(rom_addr), 64'(idx[13:0]));
      if (fetch_resp) begin lat = k; got_i = fetch_instr; got_e = fetch_err; end
    end
    chk("f_lat", 64'(lat), 64'(exp_lat));
    chk("f_err", 64'(got_e), 64'(err));
    chk("f_instr", 64'(got_i), 64'(exp_i));
    $display("fetch addr=%h instr=%h err=%0d lat=%0d", addr, got_i, got_e, lat);
  endtask

  function automatic logic [31:0] rand_main_addr();
    logic [31:0] a;
    if ($urandom_range(0, 9) == 0) a = DATA_START - $urandom_range(1, 64);
    else a = DATA_START + $urandom_range(0, 65540);
    return a;
  endfunction

  initial begin
    int resp_seen;
    logic [1:0] rs;
    logic [31:0] ra;
    for (int i = 0; i < 65536; i++) begin
      ram_mem[i] = 8'(i * 7 + 3);
      ref_ram[i] = 8'(i * 7 + 3);
    end
    rd1 = 8'd0; ram_rdata = 8'd0; rom_q = 32'd0;
    rst_n = 1'b0; main_valid = 1'b0; main_we = 1'b0; main_size = 2'd0; main_uns = 1'b0;
    main_addr = 32'd0; main_wdata = 32'd0; fetch_valid = 1'b0; fetch_addr = 32'd0;

    repeat (2) @(negedge clk);
    chk("rst_zero", 64'(|{main_ready, main_resp, main_rdata, main_err, fetch_ready, fetch_resp,
                         fetch_err, fetch_instr, ram_addr, ram_wdata, ram_we, ram_re,
                         rom_addr, rom_re}), 64'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_low", 64'({main_ready, fetch_ready}), 64'd0);
    @(negedge clk);
    chk("rdy_high", 64'({main_ready, fetch_ready}), 64'd3);

    main_txn(1'b1, 2'd2, 1'b0, 32'hC000_0010, 32'h1234_5678);
    main_txn(1'b0, 2'd0, 1'b0, 32'hC000_0013, 32'd0);
    main_txn(1'b0, 2'd1, 1'b0, 32'hC000_0012, 32'd0);
    main_txn(1'b1, 2'd0, 1'b0, 32'hC000_0020, 32'hAAAA_AA80);
    main_txn(1'b0, 2'd0, 1'b1, 32'hC000_0020, 32'd0);
    main_txn(1'b0, 2'd0, 1'b0, 32'hC000_0020, 32'd0);
    repeat (3) @(negedge clk);
    chk("held", 64'(main_rdata), 64'hFFFF_FF80);

    main_txn(1'b0, 2'd1, 1'b0, 32'hC000_0001, 32'd0);
    main_txn(1'b0, 2'd3, 1'b0, 32'hC000_0010, 32'd0);
    main_txn(1'b0, 2'd2, 1'b0, 32'hBFFF_FFFC, 32'd0);
    main_txn(1'b1, 2'd2, 1'b0, 32'hC000_FFFE, 32'h1111_2222);
    main_txn(1'b1, 2'd2, 1'b0, 32'hC000_FFFC, 32'hCAFE_F00D);
    main_txn(1'b0, 2'd2, 1'b0, 32'hC000_FFFC, 32'd0);
    main_txn(1'b0, 2'd0, 1'b0, 32'hC001_0000, 32'd0);

    fork
      main_txn(1'b0, 2'd2, 1'b0, 32'hC000_0010, 32'd0);
      fetch_txn(32'h8000_0008);
    join
    fetch_txn(32'h8000_0002);
    fetch_txn(32'h7FFF_FFFC);
    fetch_txn(32'h8000_FFFC);
    fetch_txn(32'h8001_0000);

    // Reset pulse in cycle 2 of a word store: only byte 0 reaches the RAM
    @(negedge clk);
    main_valid = 1'b1; main_we = 1'b1; main_size = 2'd2; main_uns = 1'b0;
    main_addr = 32'hC000_0040; main_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1 main_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    #1 chk("rst_mid_zero", 64'(|{main_ready, main_resp, main_rdata, main_err, fetch_ready,
                              fetch_resp, fetch_err, fetch_instr, ram_addr, ram_wdata,
                              ram_we, ram_re, rom_addr, rom_re}), 64'd0);
    #1 rst_n = 1'b1;
    ref_ram[16'h0040] = 8'hEF;
    resp_seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (main_resp) resp_seen++;
      if (k == 1) chk("rst_rdy", 64'(main_ready), 64'd1);
    end
    chk("rst_noresp", 64'(resp_seen), 64'd0);
    $display("main reset-abort store addr=c0000040 responses=%0d", resp_seen);
    main_txn(1'b0, 2'd2, 1'b0, 32'hC000_0040, 32'd0);

    fork
      for (int t = 0; t < 50; t++) begin
        rs = ($urandom_range(0, 9) == 9) ? 2'd3 : 2'($urandom_range(0, 2));
        ra = rand_main_addr();
        if ($urandom_range(0, 3) != 0) ra = (rs == 2'd2) ? {ra[31:2], 2'b00}
                                          : (rs == 2'd1) ? {ra[31:1], 1'b0} : ra;
        main_txn(1'($urandom_range(0, 1)), rs, 1'($urandom_range(0, 1)), ra, $urandom);
      end
      for (int t = 0; t < 50; t++) begin
        logic [31:0] fa;
        if ($urandom_range(0, 9) == 0) fa = CODE_START - $urandom_range(1, 64);
        else fa = CODE_START + $urandom_range(0, 70000);
        if ($urandom_range(0, 3) != 0) fa = {fa[31:2], 2'b00};
        fetch_txn(fa);
      end
    join

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
